cgra_stream_stim_gen: RTL and testbench

CGRA_STREAM_STIM_GEN -- requirements
Module: cgra_stream_stim_gen

---
 rtl/cgra_stim_pkg.sv | 25 ++
 rtl/cgra_lane_gen.sv | 66 ++++++
 rtl/cgra_stream_stim_gen.sv | 122 ++++++++++++
 tb/tb_cgra_stream_stim_gen.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cgra_stim_pkg.sv
// Shared types and defaults for the CGRA stream stimulus generator.
//   phase_e : top-level FSM state; the numeric encoding is driven out on `phase`
//   mode_e  : generator mode, latched when the FSM enters RUN
//   DEF_*   : default generator seed and Galois LFSR tap mask
package cgra_stim_pkg;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_CONFIG = 2'd1,
    PH_RUN    = 2'd2,
    PH_DONE   = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    MODE_LFSR  = 2'd0,
    MODE_CNT   = 2'd1,
    MODE_CONST = 2'd2,
    MODE_WALK  = 2'd3
  } mode_e;

  // Tap mask for x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] DEF_POLY = 16'hB400;
  localparam logic [15:0] DEF_SEED = 16'hACE1;

endpackage

// File: rtl/cgra_lane_gen.sv
// One lane of stimulus. Holds the LFSR, counter base and walking-one index
// for lane LANE_IDX; the selected mode picks which one is driven on `data`.
//   clk, rst : clock, async active-high reset (reloads seeds)
//   clear    : synchronous reload to the reset values
//   adv      : step every generator by one word (read handshake)
//   mode     : latched generator mode
//   data     : current lane word
module cgra_lane_gen import cgra_stim_pkg::*; #(
  parameter int          WIDTH    = 16,
  parameter int          LANE_IDX = 0,
  parameter logic [15:0] SEED     = DEF_SEED,
  parameter logic [15:0] POLY     = DEF_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             adv,
  input  mode_e            mode,
  output logic [WIDTH-1:0] data
);
  localparam int             IW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] SEED_X  = WIDTH'(SEED) ^ WIDTH'(LANE_IDX);
  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [WIDTH-1:0] LFSR_INIT = (SEED_X == '0) ? WIDTH'(1) : SEED_X;
  localparam logic [WIDTH-1:0] POLY_W  = WIDTH'(POLY);
  localparam logic [IW:0]      WLIM    = (IW+1)'(WIDTH);
  localparam logic [IW:0]      LOFS    = (IW+1)'(LANE_IDX % WIDTH);

  logic [WIDTH-1:0] lfsr_q, base_q, walk;
  logic [IW-1:0]    widx_q;
  logic [IW:0]      wsum, wpos;

  // Lane offset is applied at the output so all lanes share one index scheme.
  always_comb begin
    wsum = {1'b0, widx_q} + LOFS;
    wpos = (wsum >= WLIM) ? (wsum - WLIM) : wsum;
    walk = WIDTH'(1) << wpos[IW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_INIT;
      base_q <= '0;
      widx_q <= '0;
    end else if (clear) begin
      lfsr_q <= LFSR_INIT;
      base_q <= '0;
      widx_q <= '0;
    end else if (adv) begin
      lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY_W : '0);
      base_q <= base_q + WIDTH'(1);
      widx_q <= (widx_q == IW'(WIDTH-1)) ? '0 : widx_q + IW'(1);
    end
  end

  always_comb begin
    data = lfsr_q;
    case (mode)
      MODE_CNT:   data = base_q + WIDTH'(LANE_IDX);
      MODE_CONST: data = WIDTH'(SEED);
      MODE_WALK:  data = walk;
      default:    data = lfsr_q;
    endcase
  end

endmodule

// File: rtl/cgra_stream_stim_gen.sv
// Stream stimulus generator for CGRA power/functional runs.
// IDLE -> CONFIG (CONFIG_CYCLES) -> RUN (RUN_CYCLES) -> DONE. During RUN it
// offers a LANES-wide stimulus word and captures the DUT's write beats.
//   clk, rst_n    : clock; rst_n is an async ACTIVE-HIGH reset despite its name
//   flush, start  : sync restart to IDLE (wins over start) / leave IDLE
//   mode          : generator mode, sampled on CONFIG->RUN
//   read_*        : stimulus word out, advances on read_valid && read_en
//   write_*       : DUT output beats, counted and XOR-folded in RUN only
//   phase, toggle_active, done : FSM state, RUN window marker, DONE flag
//   words_out, words_in, checksum : saturating beat counters, XOR fold
module cgra_stream_stim_gen import cgra_stim_pkg::*; #(
  parameter int          LANES         = 1,
  parameter int          WIDTH         = 16,
  parameter int          CONFIG_CYCLES = 410,
  parameter int          RUN_CYCLES    = 1000,
  parameter logic [15:0] SEED          = DEF_SEED,
  parameter logic [15:0] POLY          = DEF_POLY
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic                   read_en,
  output logic [LANES*WIDTH-1:0] read_data,
  output logic                   read_valid,
  input  logic                   write_valid,
  input  logic [LANES*WIDTH-1:0] write_data,
  output logic [1:0]             phase,
  output logic                   toggle_active,
  output logic                   done,
  output logic [31:0]            words_out,
  output logic [31:0]            words_in,
  output logic [WIDTH-1:0]       checksum
);
  phase_e                        state_q, state_d;
  logic [31:0]                   cnt_q, cnt_d;
  mode_e                         mode_q;
  logic                          hs, wr_beat;
  logic [LANES-1:0][WIDTH-1:0]   lane_data;
  logic [WIDTH-1:0]              wr_fold;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      PH_IDLE: if (start) begin
        state_d = PH_CONFIG;
        cnt_d   = '0;
      end
      PH_CONFIG: if (cnt_q == 32'(CONFIG_CYCLES - 1)) begin
        state_d = PH_RUN;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 32'd1;
      PH_RUN: if (cnt_q == 32'(RUN_CYCLES - 1)) begin
        state_d = PH_DONE;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 32'd1;
      default: ;
    endcase
    if (flush) begin
      state_d = PH_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= PH_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_LFSR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Leaving the mode at LFSR after a restart makes IDLE show the seed.
      if (flush) mode_q <= MODE_LFSR;
      else if (state_q == PH_CONFIG && state_d == PH_RUN) mode_q <= mode_e'(mode);
    end
  end

  assign read_valid    = (state_q == PH_RUN);
  assign toggle_active = (state_q == PH_RUN);
  assign done          = (state_q == PH_DONE);
  assign phase         = state_q;
  assign hs            = read_valid && read_en;
  assign wr_beat       = read_valid && write_valid;

  always_comb begin
    wr_fold = '0;
    for (int i = 0; i < LANES; i++) wr_fold ^= write_data[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      words_out <= '0;
      words_in  <= '0;
      checksum  <= '0;
    end else if (flush) begin
      words_out <= '0;
      words_in  <= '0;
      checksum  <= '0;
    end else begin
      if (hs && words_out != '1) words_out <= words_out + 32'd1;
      if (wr_beat) begin
        if (words_in != '1) words_in <= words_in + 32'd1;
        checksum <= checksum ^ wr_fold;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    cgra_lane_gen #(
      .WIDTH(WIDTH), .LANE_IDX(i), .SEED(SEED), .POLY(POLY)
    ) u_lane (
      .clk(clk), .rst(rst_n), .clear(flush), .adv(hs),
      .mode(mode_q), .data(lane_data[i])
    );
  end

  assign read_data = lane_data;

endmodule

// File: tb/tb_cgra_stream_stim_gen.sv
// Self-checking bench for cgra_stream_stim_gen: directed scenarios plus
// randomized runs, compared every cycle against an elapsed-time reference.
module tb_cgra_stream_stim_gen;
  localparam int          LANES = 2;
  localparam int          WIDTH = 16;
  localparam int          CFG   = 4;
  localparam int          RUN   = 8;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam logic [15:0] POLY  = 16'hB400;

  logic                   clk = 1'b0;
  logic                   rst_n, flush, start, read_en, write_valid;
  logic [1:0]             mode;
  logic [LANES*WIDTH-1:0] read_data, write_data;
  logic                   read_valid, toggle_active, done;
  logic [1:0]             phase;
  logic [31:0]            words_out, words_in;
  logic [WIDTH-1:0]       checksum;

  int n_tests = 0;
  int n_fail  = 0;

  cgra_stream_stim_gen #(
    .LANES(LANES), .WIDTH(WIDTH), .CONFIG_CYCLES(CFG), .RUN_CYCLES(RUN),
    .SEED(SEED), .POLY(POLY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .mode(mode),
    .read_en(read_en), .read_data(read_data), .read_valid(read_valid),
    .write_valid(write_valid), .write_data(write_data), .phase(phase),
    .toggle_active(toggle_active), .done(done), .words_out(words_out),
    .words_in(words_in), .checksum(checksum)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference: phase follows from cycles elapsed since start; lane values
  // follow from the number of handshakes since the last restart.
  bit          started;
  int          d, k, m_mode;
  logic [31:0] m_wo, m_wi;
  logic [15:0] m_cs;

  task automatic m_reset();
    started = 0; d = 0; k = 0; m_mode = 0;
    m_wo = 0; m_wi = 0; m_cs = 0;
  endtask

  function automatic int m_phase();
    if (!started)       return 0;
    if (d <= CFG)       return 1;
    if (d <= CFG + RUN) return 2;
    return 3;
  endfunction

  function automatic logic [15:0] exp_lane(int i);
    logic [15:0] s;
    case (m_mode)
      1: return 16'((k + i) % 65536);
      2: return SEED;
      3: return 16'(1) << ((k + i) % WIDTH);
      default: begin
        s = SEED ^ 16'(i);
        if (s == 16'h0) s = 16'h1;
        for (int t = 0; t < k; t++) s = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
        return s;
      end
    endcase
  endfunction

  task automatic check_all();
    int ph;
    ph = m_phase();
    chk("phase", phase, ph);
    chk("read_valid", read_valid, ph == 2);
    chk("toggle_active", toggle_active, ph == 2);
    chk("done", done, ph == 3);
    chk("words_out", words_out, m_wo);
    chk("words_in", words_in, m_wi);
    chk("checksum", checksum, m_cs);
    for (int i = 0; i < LANES; i++)
      chk("read_data", read_data[i*WIDTH +: WIDTH], exp_lane(i));
  endtask

  // One clock: check the settled outputs, drive the next inputs, advance the model.
  task automatic cyc(input logic f, input logic s, input logic [1:0] md,
                     input logic re, input logic wv, input logic [31:0] wd);
    int ph;
    @(negedge clk);
    check_all();
    flush = f; start = s; mode = md; read_en = re; write_valid = wv; write_data = wd;
    ph = m_phase();
    if (f) m_reset();
    else begin
      if (ph == 0 && s) begin started = 1; d = 0; end
      if (ph == 1 && d == CFG) m_mode = int'(md);
      if (ph == 2) begin
        if (re) begin k++; m_wo++; end
        if (wv) begin
          m_wi++;
          for (int i = 0; i < LANES; i++) m_cs ^= wd[i*WIDTH +: WIDTH];
        end
      end
      if (started) d++;
    end
  endtask

  initial begin
    rst_n = 1'b1; flush = 0; start = 0; mode = 0; read_en = 0;
    write_valid = 0; write_data = '0;
    m_reset();
    #1 check_all();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b0;

    // LFSR run, read_en held, write beats 0001/0003 alternating on lane 0.
    cyc(0, 1, 2'd0, 1, 0, 0);
    for (int j = 0; j < CFG + RUN + 2; j++)
      cyc(0, 0, 2'd0, 1, 1, (j % 2 == 0) ? 32'h0000_0001 : 32'h0000_0003);
    @(negedge clk);
    chk("lfsr_done", done, 1'b1);
    chk("lfsr_words_out", words_out, 32'd8);
    chk("lfsr_words_in", words_in, 32'd8);
    chk("lfsr_checksum", checksum, 16'h0000);

    // Counter run with read_en toggling: each word held for two cycles.
    cyc(1, 0, 2'd1, 0, 0, 0);
    cyc(0, 1, 2'd1, 1, 0, 0);
    for (int j = 0; j < CFG + RUN + 2; j++)
      cyc(0, 0, 2'd1, (j % 2 == 0), 0, 0);
    @(negedge clk);
    chk("cnt_words_out", words_out, 32'd4);
    chk("cnt_lane1", read_data[WIDTH +: WIDTH], 16'd5);

    // Flush together with start on the seventh RUN cycle.
    cyc(1, 0, 2'd3, 0, 0, 0);
    cyc(0, 1, 2'd3, 1, 1, 0);
    for (int j = 0; j < CFG + 6; j++) cyc(0, 0, 2'd3, 1, 1, $urandom());
    cyc(1, 1, 2'd3, 1, 1, $urandom());
    @(negedge clk);
    chk("flush_phase", phase, 2'd0);
    chk("flush_words_out", words_out, 32'd0);
    for (int j = 0; j < 3; j++) cyc(0, 0, 2'd0, 1, 1, $urandom());

    // Randomized runs; mode wiggles every cycle, only the CONFIG->RUN value sticks.
    for (int r = 0; r < 16; r++) begin
      cyc(1, 0, 2'($urandom_range(0, 3)), 0, 0, 0);
      cyc(0, 1, 2'($urandom_range(0, 3)), 0, 0, 0);
      for (int j = 0; j < CFG + RUN + 3; j++)
        cyc(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom());
    end

    // Asynchronous reset in the middle of RUN.
    cyc(1, 0, 2'd1, 0, 0, 0);
    cyc(0, 1, 2'd1, 1, 1, 0);
    for (int j = 0; j < CFG + 3; j++) cyc(0, 0, 2'd1, 1, 1, $urandom());
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 m_reset();
    check_all();
    chk("areset_phase", phase, 2'd0);
    @(negedge clk);
    rst_n = 1'b0;
    for (int j = 0; j < 4; j++) cyc(0, 0, 2'd1, 1, 1, $urandom());
    chk("areset_idle_wait", phase, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
